// File: rtl/uart_pkg.sv
// Shared encodings and constants for the FIFO-buffered UART.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_t;

    localparam int OVS       = 16;
    localparam int START_MID = 7;
    localparam int CNT_W     = 5;
    localparam int NB_W      = 4;

endpackage

// File: rtl/uart_fifo_top_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; dout reads 0 while empty.
module sync_fifo #(
    parameter int W      = 8,
    parameter int ADDR_W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [W-1:0]      r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_cnt;
    logic              w_do_rd;
    logic              w_do_wr;

    assign empty   = (r_cnt == '0);
    assign full    = (r_cnt == (ADDR_W+1)'(DEPTH));
    assign w_do_rd = rd & ~empty;
    // A pop frees the slot, so a write to a full FIFO succeeds alongside a read.
    assign w_do_wr = wr & (~full | w_do_rd);
    assign dout    = empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_do_wr)
            r_mem[r_wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_do_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_do_rd)
                r_rptr <= r_rptr + 1'b1;
            unique case ({w_do_wr, w_do_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_top.sv
// UART with baud generator, configurable frame and TX/RX FIFOs;
// RX words carry their own parity/framing flags.
module uart_fifo_top
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_W     = 2,
    parameter int DVSR_W     = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              wr_uart,
    input  logic [DBIT-1:0]   w_data,
    output logic              tx_full,
    input  logic              rd_uart,
    output logic [DBIT-1:0]   r_data,
    output logic              r_perr,
    output logic              r_ferr,
    output logic              rx_empty,
    output logic              overrun,
    input  logic              clr_ovr,
    input  logic              rx,
    output logic              tx
);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(OVS - 1);
    localparam logic [CNT_W-1:0] C_MID  = CNT_W'(START_MID);
    localparam logic [CNT_W-1:0] C_STOP = CNT_W'(SB_TICK - 1);
    localparam logic [NB_W-1:0]  N_LAST = NB_W'(DBIT - 1);
    localparam logic             P_ODD  = 1'(PARITY_ODD);

    logic [DVSR_W-1:0] r_bcnt;
    logic [DVSR_W-1:0] r_dvsr;
    logic              w_tick;

    // Divisor is latched at each wrap so a change never truncates a period.
    assign w_tick = (r_bcnt == r_dvsr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcnt <= '0;
            r_dvsr <= dvsr;
        end else if (w_tick) begin
            r_bcnt <= '0;
            r_dvsr <= dvsr;
        end else begin
            r_bcnt <= r_bcnt + 1'b1;
        end
    end

    uart_state_t      r_tx_st;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [NB_W-1:0]  r_tx_n;
    logic [DBIT-1:0]  r_tx_sh;
    logic             r_tx_par;
    logic             r_tx;
    logic [DBIT-1:0]  w_tx_dout;
    logic             w_tx_empty;
    logic             w_tx_rd;
    logic             w_tx_stop_done;

    assign w_tx_stop_done = (r_tx_st == S_STOP) && w_tick && (r_tx_cnt == C_STOP);
    assign w_tx_rd = ~w_tx_empty & ((r_tx_st == S_IDLE) | w_tx_stop_done);
    assign tx = r_tx;

    sync_fifo #(.W(DBIT), .ADDR_W(FIFO_W)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (wr_uart),
        .rd    (w_tx_rd),
        .din   (w_data),
        .dout  (w_tx_dout),
        .full  (tx_full),
        .empty (w_tx_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_st  <= S_IDLE;
            r_tx_cnt <= '0;
            r_tx_n   <= '0;
            r_tx_sh  <= '0;
            r_tx_par <= 1'b0;
            r_tx     <= 1'b1;
        end else begin
            if (w_tx_rd) begin
                r_tx_st  <= S_START;
                r_tx_cnt <= '0;
                r_tx_sh  <= w_tx_dout;
                r_tx_par <= ^w_tx_dout ^ P_ODD;
            end else begin
                unique case (r_tx_st)
                    S_IDLE: ;
                    S_START:
                        if (w_tick) begin
                            if (r_tx_cnt == C_LAST) begin
                                r_tx_st  <= S_DATA;
                                r_tx_cnt <= '0;
                                r_tx_n   <= '0;
                            end else
                                r_tx_cnt <= r_tx_cnt + 1'b1;
                        end
                    S_DATA:
                        if (w_tick) begin
                            if (r_tx_cnt == C_LAST) begin
                                r_tx_cnt <= '0;
                                r_tx_sh  <= r_tx_sh >> 1;
                                if (r_tx_n == N_LAST)
                                    r_tx_st <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                                else
                                    r_tx_n <= r_tx_n + 1'b1;
                            end else
                                r_tx_cnt <= r_tx_cnt + 1'b1;
                        end
                    S_PARITY:
                        if (w_tick) begin
                            if (r_tx_cnt == C_LAST) begin
                                r_tx_st  <= S_STOP;
                                r_tx_cnt <= '0;
                            end else
                                r_tx_cnt <= r_tx_cnt + 1'b1;
                        end
                    S_STOP:
                        if (w_tick) begin
                            if (r_tx_cnt == C_STOP) begin
                                r_tx_st  <= S_IDLE;
                                r_tx_cnt <= '0;
                            end else
                                r_tx_cnt <= r_tx_cnt + 1'b1;
                        end
                    default: r_tx_st <= S_IDLE;
                endcase
            end
            unique case (r_tx_st)
                S_START:  r_tx <= 1'b0;
                S_DATA:   r_tx <= r_tx_sh[0];
                S_PARITY: r_tx <= r_tx_par;
                default:  r_tx <= 1'b1;
            endcase
        end
    end

    uart_state_t      r_rx_st;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [NB_W-1:0]  r_rx_n;
    logic [DBIT-1:0]  r_rx_sh;
    logic             r_rx_perr;
    logic             r_ovr;
    logic             w_rx_push;
    logic             w_rx_full;
    logic [DBIT+1:0]  w_rx_din;
    logic [DBIT+1:0]  w_rx_dout;

    assign w_rx_push = (r_rx_st == S_STOP) && w_tick && (r_rx_cnt == C_STOP);
    assign w_rx_din  = {~rx, r_rx_perr, r_rx_sh};
    assign r_data    = w_rx_dout[DBIT-1:0];
    assign r_perr    = w_rx_dout[DBIT];
    assign r_ferr    = w_rx_dout[DBIT+1];
    assign overrun   = r_ovr;

    sync_fifo #(.W(DBIT + 2), .ADDR_W(FIFO_W)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (w_rx_push),
        .rd    (rd_uart),
        .din   (w_rx_din),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_st   <= S_IDLE;
            r_rx_cnt  <= '0;
            r_rx_n    <= '0;
            r_rx_sh   <= '0;
            r_rx_perr <= 1'b0;
        end else begin
            unique case (r_rx_st)
                S_IDLE:
                    if (!rx) begin
                        r_rx_st  <= S_START;
                        r_rx_cnt <= '0;
                    end
                S_START:
                    if (w_tick) begin
                        if (r_rx_cnt == C_MID) begin
                            r_rx_st   <= rx ? S_IDLE : S_DATA;
                            r_rx_cnt  <= '0;
                            r_rx_n    <= '0;
                            r_rx_perr <= 1'b0;
                        end else
                            r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                S_DATA:
                    if (w_tick) begin
                        if (r_rx_cnt == C_LAST) begin
                            r_rx_cnt <= '0;
                            r_rx_sh  <= {rx, r_rx_sh[DBIT-1:1]};
                            if (r_rx_n == N_LAST)
                                r_rx_st <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                            else
                                r_rx_n <= r_rx_n + 1'b1;
                        end else
                            r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                S_PARITY:
                    if (w_tick) begin
                        if (r_rx_cnt == C_LAST) begin
                            r_rx_st   <= S_STOP;
                            r_rx_cnt  <= '0;
                            r_rx_perr <= rx ^ (^r_rx_sh) ^ P_ODD;
                        end else
                            r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                S_STOP:
                    if (w_tick) begin
                        if (r_rx_cnt == C_STOP) begin
                            r_rx_st  <= S_IDLE;
                            r_rx_cnt <= '0;
                        end else
                            r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                default: r_rx_st <= S_IDLE;
            endcase
        end
    end

    // A simultaneous pop makes room, so only a true drop counts as overrun.
    always_ff @(posedge clk) begin
        if (reset)
            r_ovr <= 1'b0;
        else if (w_rx_push && w_rx_full && !rd_uart)
            r_ovr <= 1'b1;
        else if (clr_ovr)
            r_ovr <= 1'b0;
    end

endmodule
